// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU address-generation blocks.
//   WORD_W        : datapath word width (fixed at 16 for the Hack ISA)
//   LEN_W         : width of a burst-length field
//   sched_state_t : incrementor scheduler state
package hack_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } sched_state_t;

endpackage

// File: rtl/inc16.sv
// Arithmetic library: WORD_W-bit incrementor.
// Ports:
//   a_i     : operand
//   sum_o   : a_i + 1, modulo 2^WORD_W
//   carry_o : the increment wrapped from all-ones to zero
module inc16
  import hack_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              carry_o
);

  logic [WORD_W:0] full;

  assign full    = {1'b0, a_i} + {{WORD_W{1'b0}}, 1'b1};
  assign sum_o   = full[WORD_W-1:0];
  assign carry_o = full[WORD_W];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req_i   : request vector
//   ptr_i   : highest-priority index; the search wraps modulo NUM_REQ
//   en_i    : grant enable (the index search itself is not gated)
//   gnt_o   : one-hot grant, all zero when disabled or nothing requested
//   idx_o   : encoded index of the winner (0 when none)
//   found_o : at least one request is pending
module rr_arbiter
  import hack_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 3,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               found_o
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    found = 1'b0;
    idx_o = '0;
    sum   = '0;
    cand  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      // ptr_i < NUM_REQ and off < NUM_REQ, so one subtraction does the modulo.
      sum = {1'b0, ptr_i} + (IDX_W + 1)'(off);
      if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
        sum = sum - (IDX_W + 1)'(NUM_REQ);
      end
      cand = sum[IDX_W-1:0];
      if (!found && req_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
  end

  assign found_o = found;
  assign gnt_o   = (found && en_i) ? (NUM_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/inc16_sched.sv
// Time-shares one 16-bit incrementor among NUM_REQ requesters. Each grant is a
// burst of 1..15 increments from a supplied base, one result per cycle.
// Round-robin arbitration happens only between bursts; the next burst may be
// granted on the last word of the current one so bursts run back-to-back.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req_valid  : per-requester request
//   req_ready  : one-hot grant (combinational)
//   req_data   : packed base values, requester i at [i*WIDTH +: WIDTH]
//   req_len    : packed burst lengths, requester i at [i*LEN_W +: LEN_W]; 0 means 1
//   rsp_valid  : result word valid
//   rsp_id     : owning requester
//   rsp_data   : incremented value
//   rsp_carry  : this increment wrapped 0xFFFF -> 0x0000
//   rsp_last   : final word of the burst
//   busy       : a burst is in progress
module inc16_sched #(
  parameter  int unsigned NUM_REQ = 3,
  parameter  int unsigned WIDTH   = 16,
  parameter  int unsigned LEN_W   = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_data,
  output logic                     rsp_carry,
  output logic                     rsp_last,
  output logic                     busy
);

  import hack_pkg::*;

  sched_state_t     state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;

  logic               can_accept;
  logic               last_word;
  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_found;
  logic               hs;
  logic [WIDTH-1:0]   sel_data;
  logic [LEN_W-1:0]   sel_len;
  logic [WIDTH-1:0]   inc_sum;
  logic               inc_carry;

  assign last_word  = (state_q == BURST) && (remaining_q == LEN_W'(1));
  assign can_accept = (state_q == IDLE) || last_word;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .en_i    (can_accept),
    .gnt_o   (gnt),
    .idx_o   (gnt_idx),
    .found_o (gnt_found)
  );

  assign req_ready = gnt;
  assign hs        = gnt_found && can_accept;
  assign sel_data  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
  assign sel_len   = req_len[int'(gnt_idx)*LEN_W +: LEN_W];

  // The only adder: feeds both the response and the base update.
  inc16 u_inc (
    .a_i     (base_q),
    .sum_o   (inc_sum),
    .carry_o (inc_carry)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    base_d      = base_q;
    remaining_d = remaining_q;

    if (state_q == BURST) begin
      base_d      = inc_sum;
      remaining_d = remaining_q - LEN_W'(1);
      if (last_word) begin
        state_d = IDLE;
      end
    end

    // A handshake overrides the burst-end transition, giving no bubble.
    if (hs) begin
      state_d     = BURST;
      base_d      = sel_data;
      remaining_d = (sel_len == '0) ? LEN_W'(1) : sel_len;
      owner_d     = gnt_idx;
      rr_ptr_d    = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      base_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      base_q      <= base_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs are gated to zero outside a burst so stale base/owner never leak.
  always_comb begin
    busy      = (state_q == BURST);
    rsp_valid = busy;
    rsp_data  = busy ? inc_sum : '0;
    rsp_carry = busy && inc_carry;
    rsp_id    = busy ? owner_q : '0;
    rsp_last  = last_word;
  end

endmodule

// File: tb/tb_inc16_sched.sv
module tb_inc16_sched;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N*16-1:0] req_data = '0;
  logic [N*4-1:0]  req_len = '0;
  logic          rsp_valid;
  logic [1:0]    rsp_id;
  logic [15:0]   rsp_data;
  logic          rsp_carry;
  logic          rsp_last;
  logic          busy;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] d;
    logic        c;
    logic        l;
  } word_t;

  word_t m_q[$];
  int    m_ptr;

  always #5 clk = ~clk;

  inc16_sched #(
    .NUM_REQ (N),
    .WIDTH   (16),
    .LEN_W   (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_len   (req_len),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_last  (rsp_last),
    .busy      (busy)
  );

  // Observed outputs as {valid, id, data, carry, last, busy, ready}.
  function automatic logic [24:0] obs();
    return {rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_last, busy, req_ready};
  endfunction

  function automatic logic [24:0] ev(logic v, logic [1:0] id, logic [15:0] d, logic c,
                                     logic l, logic b, logic [2:0] rdy);
    return {v, id, d, c, l, b, rdy};
  endfunction

  function automatic logic [2:0] onehot(int i);
    return 3'(1 << i);
  endfunction

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_q.delete();
    m_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    #2;
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0))
      $display("FAIL reset_asserted: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 0));
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) fails++;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) begin
        fails++;
        $display("FAIL idle_after_reset cyc%0d: got %h want %h", i, obs(),
                 ev(0, 0, 0, 0, 0, 0, 0));
      end
    end
  endtask

  task automatic test_single();
    apply_reset();
    req_valid = 3'b001;
    req_data[0 +: 16] = 16'h0010;
    req_len[0 +: 4]   = 4'd3;
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 3'b001)) begin
      fails++;
      $display("FAIL single_grant: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 3'b001));
    end
    @(posedge clk);
    #1 req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== ev(1, 0, 16'(16'h0011 + i), 0, (i == 2), 1, 0)) begin
        fails++;
        $display("FAIL single_word%0d: got %h want %h", i, obs(),
                 ev(1, 0, 16'(16'h0011 + i), 0, (i == 2), 1, 0));
      end
    end
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL single_end: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_wrap();
    logic [15:0] wd[3];
    logic        wc[3];
    wd[0] = 16'hFFFF; wd[1] = 16'h0000; wd[2] = 16'h0001;
    wc[0] = 1'b0;     wc[1] = 1'b1;     wc[2] = 1'b0;
    apply_reset();
    req_valid = 3'b010;
    req_data[16 +: 16] = 16'hFFFE;
    req_len[4 +: 4]    = 4'd3;
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 3'b010)) begin
      fails++;
      $display("FAIL wrap_grant: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 3'b010));
    end
    @(posedge clk);
    #1 req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== ev(1, 1, wd[i], wc[i], (i == 2), 1, 0)) begin
        fails++;
        $display("FAIL wrap_word%0d: got %h want %h", i, obs(),
                 ev(1, 1, wd[i], wc[i], (i == 2), 1, 0));
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req_valid = 3'b111;
    for (int i = 0; i < N; i++) begin
      req_data[i*16 +: 16] = 16'((i + 1) << 8);
      req_len[i*4 +: 4]    = 4'd1;
    end
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 3'b001)) begin
      fails++;
      $display("FAIL rr_first: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 3'b001));
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      tests++;
      if (obs() !== ev(1, 2'(k % 3), 16'(((k % 3 + 1) << 8) | 1), 0, 1, 1,
                       onehot((k + 1) % 3))) begin
        fails++;
        $display("FAIL rr_word%0d: got %h want %h", k, obs(),
                 ev(1, 2'(k % 3), 16'(((k % 3 + 1) << 8) | 1), 0, 1, 1, onehot((k + 1) % 3)));
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    tests++;
    if (obs() !== ev(1, 0, 16'h0101, 0, 1, 1, 0)) begin
      fails++;
      $display("FAIL rr_tail: got %h want %h", obs(), ev(1, 0, 16'h0101, 0, 1, 1, 0));
    end
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL rr_end: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_len0();
    apply_reset();
    req_valid = 3'b100;
    req_data[32 +: 16] = 16'h7FFF;
    req_len[8 +: 4]    = 4'd0;
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 3'b100)) begin
      fails++;
      $display("FAIL len0_grant: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 3'b100));
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    tests++;
    if (obs() !== ev(1, 2, 16'h8000, 0, 1, 1, 0)) begin
      fails++;
      $display("FAIL len0_word: got %h want %h", obs(), ev(1, 2, 16'h8000, 0, 1, 1, 0));
    end
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL len0_end: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 0));
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req_valid = 3'b001;
    req_data[0 +: 16] = 16'h0000;
    req_len[0 +: 4]   = 4'd10;
    @(posedge clk);
    #1 req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (obs() !== ev(1, 0, 16'(i + 1), 0, 0, 1, 0)) begin
        fails++;
        $display("FAIL mid_word%0d: got %h want %h", i, obs(), ev(1, 0, 16'(i + 1), 0, 0, 1, 0));
      end
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs() !== ev(1, 0, 16'h0004, 0, 0, 1, 0)) begin
      fails++;
      $display("FAIL mid_word3: got %h want %h", obs(), ev(1, 0, 16'h0004, 0, 0, 1, 0));
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 0)) begin
      fails++;
      $display("FAIL mid_abort: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    // Pointer was 1 before the abort; a reset pointer must pick requester 0.
    req_valid = 3'b011;
    req_data[0 +: 16]  = 16'h0050;
    req_len[0 +: 4]    = 4'd1;
    req_data[16 +: 16] = 16'h1234;
    req_len[4 +: 4]    = 4'd2;
    @(negedge clk);
    tests++;
    if (obs() !== ev(0, 0, 0, 0, 0, 0, 3'b001)) begin
      fails++;
      $display("FAIL mid_ptr_reset: got %h want %h", obs(), ev(0, 0, 0, 0, 0, 0, 3'b001));
    end
    @(posedge clk);
    #1 req_valid = 3'b010;
    @(negedge clk);
    tests++;
    if (obs() !== ev(1, 0, 16'h0051, 0, 1, 1, 3'b010)) begin
      fails++;
      $display("FAIL mid_req0: got %h want %h", obs(), ev(1, 0, 16'h0051, 0, 1, 1, 3'b010));
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    tests++;
    if (obs() !== ev(1, 1, 16'h1235, 0, 0, 1, 0)) begin
      fails++;
      $display("FAIL mid_req1a: got %h want %h", obs(), ev(1, 1, 16'h1235, 0, 0, 1, 0));
    end
    @(negedge clk);
    tests++;
    if (obs() !== ev(1, 1, 16'h1236, 0, 1, 1, 0)) begin
      fails++;
      $display("FAIL mid_req1b: got %h want %h", obs(), ev(1, 1, 16'h1236, 0, 1, 1, 0));
    end
  endtask

  // Reference: a queue of words still owed. A new burst may be granted when at
  // most one owed word remains (the one being delivered this cycle).
  task automatic test_random();
    logic [24:0] want;
    logic [2:0]  rdy;
    int          g;
    int          len;
    logic [15:0] b;
    word_t       w;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = 3'($urandom);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req_data[i*16 +: 16] = 16'(16'hFFF0 + $urandom_range(0, 15));
        else req_data[i*16 +: 16] = 16'($urandom);
        req_len[i*4 +: 4] = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3))
                                                        : 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      g = -1;
      if (m_q.size() <= 1) begin
        for (int off = 0; off < N; off++) begin
          if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
        end
      end
      rdy = (g >= 0) ? onehot(g) : 3'b000;
      if (m_q.size() > 0) want = ev(1, m_q[0].id, m_q[0].d, m_q[0].c, m_q[0].l, 1, rdy);
      else want = ev(0, 0, 0, 0, 0, 0, rdy);
      tests++;
      if (obs() !== want) begin
        fails++;
        $display("FAIL random cyc%0d: got %h want %h", cyc, obs(), want);
      end
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (g >= 0) begin
        len = int'(req_len[g*4 +: 4]);
        if (len == 0) len = 1;
        b = req_data[g*16 +: 16];
        for (int k = 0; k < len; k++) begin
          w.id = 2'(g);
          w.d  = 16'(b + 16'd1);
          w.c  = (b == 16'hFFFF);
          w.l  = (k == len - 1);
          m_q.push_back(w);
          b = w.d;
        end
        m_ptr = (g + 1) % N;
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_len0();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
